// File: rtl/sseg_display_arbiter.sv
// Round-robin arbiter granting one requester at a time ownership of a
// shared seven-segment display word, with a minimum tenure before preemption.
module sseg_display_arbiter #(
    parameter int          NUM_REQ     = 4,
    parameter int          HOLD_CYCLES = 16,
    parameter logic [15:0] IDLE_DATA   = 16'h0000
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*16-1:0]      data_in,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [15:0]                display_data,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
);

    localparam int         OW       = $clog2(NUM_REQ);
    localparam logic [7:0] HOLD_MAX = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t      state;
    logic [7:0]  hold_cnt;
    logic [OW-1:0] last_owner;
    logic [OW-1:0] winner;
    logic [15:0] slice [NUM_REQ];
    logic        others;
    logic        expire;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slice[i] = data_in[i*16 +: 16];
        end
    end

    // Lowest requester above last_owner wins; otherwise wrap to lowest overall.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) winner = OW'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (OW'(i) > last_owner)) winner = OW'(i);
        end
    end

    assign others = |(req & ~gnt);
    assign expire = (hold_cnt == HOLD_MAX) && others;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state        <= IDLE;
            gnt          <= '0;
            busy         <= 1'b0;
            owner        <= '0;
            display_data <= IDLE_DATA;
            hold_cnt     <= '0;
            last_owner   <= OW'(NUM_REQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state        <= GRANT;
                        gnt          <= NUM_REQ'(1) << winner;
                        busy         <= 1'b1;
                        owner        <= winner;
                        last_owner   <= winner;
                        hold_cnt     <= '0;
                        display_data <= slice[winner];
                    end
                end
                GRANT: begin
                    if (!req[owner] || expire) begin
                        state <= RELEASE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        display_data <= slice[owner];
                        if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Randomized and directed bench for sseg_display_arbiter against a
// tenure/gap behavioural model.
module tb_sseg_display_arbiter;

    localparam int N = 4;
    localparam int H = 4;

    logic          clk = 1'b0;
    logic          clear = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*16-1:0] data_in = '0;
    logic [N-1:0]  gnt;
    logic [15:0]   display_data;
    logic [1:0]    owner;
    logic          busy;

    int n_checks = 0;
    int n_fail = 0;

    logic        m_active;
    int          m_owner;
    int          m_last;
    int          m_tenure;
    int          m_gap;
    logic [15:0] m_disp;

    sseg_display_arbiter #(
        .NUM_REQ    (N),
        .HOLD_CYCLES(H),
        .IDLE_DATA  (16'h0000)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .req         (req),
        .data_in     (data_in),
        .gnt         (gnt),
        .display_data(display_data),
        .owner       (owner),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] slice(int i);
        return data_in[i*16 +: 16];
    endfunction

    task automatic set_slice(int i, logic [15:0] v);
        data_in[i*16 +: 16] = v;
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_owner  = 0;
        m_last   = N - 1;
        m_tenure = 0;
        m_gap    = 0;
        m_disp   = 16'h0000;
    endtask

    // One clock of the display-ownership rules, using the pre-edge inputs.
    task automatic model_edge();
        int c;
        logic [N-1:0] mine;
        if (m_active) begin
            mine = N'(1) << m_owner;
            if (!req[m_owner] || (m_tenure >= H - 1 && (req & ~mine) != 0)) begin
                m_active = 1'b0;
                m_gap    = 1;
            end else begin
                m_disp = slice(m_owner);
                m_tenure++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (req != 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (req[c]) begin
                    m_owner = c;
                    break;
                end
            end
            m_last   = m_owner;
            m_active = 1'b1;
            m_tenure = 0;
            m_disp   = slice(m_owner);
        end
    endtask

    function automatic logic [22:0] exp_vec();
        logic [N-1:0] g;
        g = m_active ? (N'(1) << m_owner) : '0;
        return {g, m_active, 2'(m_owner), m_disp};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b0;
        #2;
        clear = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        clear = 1'b0;
        req = '0;
        #3;
        model_reset();
        n_checks++;
        if ({gnt, busy, owner, display_data} !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected 0",
                     {gnt, busy, owner, display_data});
        end
        @(posedge clk);
        #1;
        clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if ({gnt, busy, owner, display_data} !== 23'h0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %h expected 0",
                         i, {gnt, busy, owner, display_data});
            end
        end
    endtask

    task automatic test_single();
        set_slice(2, 16'h8320);
        req = 4'b0100;
        step();
        n_checks++;
        if (gnt !== 4'b0100 || display_data !== 16'h8320 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b data=%h expected 0100/8320",
                     gnt, display_data);
        end
        set_slice(2, 16'hABCD);
        step();
        n_checks++;
        if (display_data !== 16'hABCD) begin
            n_fail++;
            $display("FAIL single_update: data=%h expected abcd", display_data);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if ({gnt, busy, owner, display_data} !== exp_vec()
                || gnt !== 4'b0100) begin
                n_fail++;
                $display("FAIL single_tenure cyc %0d: got %h expected %h",
                         i, {gnt, busy, owner, display_data}, exp_vec());
            end
        end
        req = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({gnt, busy, owner, display_data} !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_drop cyc %0d: got %h expected %h",
                         i, {gnt, busy, owner, display_data}, exp_vec());
            end
        end
    endtask

    task automatic test_round_robin();
        int hi = 0;
        int gap = 0;
        bit seen_fall = 0;
        logic [N-1:0] prev = '0;
        int owners[$];
        int exp_own[5] = '{0, 1, 2, 3, 0};
        pulse_clear();
        set_slice(0, 16'h1111);
        set_slice(1, 16'h2222);
        set_slice(2, 16'h3333);
        set_slice(3, 16'h4444);
        req = 4'b1111;
        for (int i = 0; i < 40; i++) begin
            step();
            n_checks++;
            if ({gnt, busy, owner, display_data} !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr_model cyc %0d: got %h expected %h",
                         i, {gnt, busy, owner, display_data}, exp_vec());
            end
            if (gnt != 0) begin
                if (prev == 0) begin
                    owners.push_back(int'(owner));
                    if (seen_fall) begin
                        n_checks++;
                        if (gap != 2) begin
                            n_fail++;
                            $display("FAIL rr_gap: got %0d expected 2", gap);
                        end
                    end
                    hi = 0;
                end
                hi++;
            end else begin
                if (prev != 0) begin
                    n_checks++;
                    if (hi != H) begin
                        n_fail++;
                        $display("FAIL rr_tenure: got %0d expected %0d", hi, H);
                    end
                    seen_fall = 1;
                    gap = 0;
                end
                gap++;
            end
            prev = gnt;
        end
        n_checks++;
        if (owners.size() < 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants expected >=5", owners.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (owners[i] != exp_own[i]) begin
                    n_fail++;
                    $display("FAIL rr_order %0d: got %0d expected %0d",
                             i, owners[i], exp_own[i]);
                end
            end
        end
        req = '0;
        repeat (3) step();
    endtask

    task automatic test_early_release();
        pulse_clear();
        set_slice(1, 16'h5A5A);
        set_slice(3, 16'h0F0F);
        req = 4'b0010;
        step();
        req = 4'b1010;
        step();
        step();
        req = 4'b1000;
        step();
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd1
            || display_data !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL early_release: gnt=%b busy=%b own=%0d data=%h expected 0000/0/1/5a5a",
                     gnt, busy, owner, display_data);
        end
        step();
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL early_gap: gnt=%b expected 0000", gnt);
        end
        step();
        n_checks++;
        if (gnt !== 4'b1000 || owner !== 2'd3 || display_data !== 16'h0F0F) begin
            n_fail++;
            $display("FAIL early_next: gnt=%b own=%0d data=%h expected 1000/3/0f0f",
                     gnt, owner, display_data);
        end
        n_checks++;
        if ({gnt, busy, owner, display_data} !== exp_vec()) begin
            n_fail++;
            $display("FAIL early_model: got %h expected %h",
                     {gnt, busy, owner, display_data}, exp_vec());
        end
        req = '0;
        repeat (8) step();
    endtask

    task automatic test_reset_mid_grant();
        pulse_clear();
        set_slice(2, 16'h7777);
        set_slice(3, 16'h9999);
        req = 4'b0100;
        step();
        step();
        clear = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || display_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset: gnt=%b busy=%b data=%h expected 0000/0/0000",
                     gnt, busy, display_data);
        end
        #2;
        clear = 1'b1;
        model_reset();
        req = 4'b1100;
        step();
        n_checks++;
        if (gnt !== 4'b0100 || owner !== 2'd2 || display_data !== 16'h7777) begin
            n_fail++;
            $display("FAIL mid_restart: gnt=%b own=%0d data=%h expected 0100/2/7777",
                     gnt, owner, display_data);
        end
        req = '0;
        repeat (3) step();
    endtask

    task automatic test_random();
        logic [N-1:0] prev = gnt;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) req = N'($urandom);
            if ($urandom_range(1) == 0) begin
                set_slice($urandom_range(N - 1), 16'($urandom));
            end
            step();
            n_checks++;
            if ({gnt, busy, owner, display_data} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model cyc %0d: got %h expected %h",
                         i, {gnt, busy, owner, display_data}, exp_vec());
            end
            n_checks++;
            if (!$onehot0(gnt) || (prev != 0 && gnt != 0 && gnt != prev)) begin
                n_fail++;
                $display("FAIL random_onehot cyc %0d: gnt=%b prev=%b", i, gnt, prev);
            end
            prev = gnt;
        end
    endtask

    // Grant must stay one-hot-or-zero on every sampled cycle of every scenario.
    always @(negedge clk) begin
        if (clear) begin
            n_checks++;
            if (!$onehot0(gnt)) begin
                n_fail++;
                $display("FAIL onehot: gnt=%b expected one-hot-or-zero", gnt);
            end
        end
    end

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
